// File: rtl/block_nest_checker_if.sv
// Byte-stream and status bundle for block_nest_checker: the source drives in_valid/in,
// the checker drives the nesting status back.
interface block_nest_checker_if #(
  parameter int unsigned CNT_W = 5
) ();
  logic             in_valid;
  logic [7:0]       in;
  logic             result;
  logic [CNT_W-1:0] depth;
  logic             top_kind;
  logic             error;
  logic             overflow;

  modport master (
    output in_valid, in,
    input  result, depth, top_kind, error, overflow
  );

  modport slave (
    input  in_valid, in,
    output result, depth, top_kind, error, overflow
  );
endinterface

// File: rtl/block_nest_checker.sv
// Streaming begin/end + fork/join nesting checker: splits space-delimited words, matches
// keywords case-insensitively and tracks block kinds on a bounded stack.
module block_nest_checker #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input logic                 clk,
  input logic                 reset,
  block_nest_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] DepthMax = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  logic [39:0]      word_q, word_d;
  logic [2:0]       len_q, len_d;
  logic             bad_q, bad_d;
  logic [DEPTH-1:0] stack_q, stack_d;
  logic [CNT_W-1:0] depth_q, depth_d;
  logic             error_q, error_d;
  logic             overflow_q, overflow_d;

  logic       top_kind;
  logic       is_letter;
  logic [7:0] ch_lower;
  logic       is_begin, is_fork, is_end, is_join;

  always_ff @(posedge clk) begin
    if (!reset) begin
      word_q     <= '0;
      len_q      <= '0;
      bad_q      <= 1'b0;
      stack_q    <= '0;
      depth_q    <= '0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      word_q     <= word_d;
      len_q      <= len_d;
      bad_q      <= bad_d;
      stack_q    <= stack_d;
      depth_q    <= depth_d;
      error_q    <= error_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry depth-1 is the innermost block; reads 0 when the stack is empty.
  always_comb begin
    top_kind = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == CNT_W'(i + 1)) top_kind = stack_q[i];
    end
  end

  // Word register shifts in the newest char at the bottom, so short keywords sit in low bytes.
  always_comb begin
    ch_lower  = bus.in;
    is_letter = (bus.in >= 8'h61) && (bus.in <= 8'h7a);
    if ((bus.in >= 8'h41) && (bus.in <= 8'h5a)) begin
      ch_lower  = bus.in | 8'h20;
      is_letter = 1'b1;
    end
    is_begin = !bad_q && (len_q == 3'd5) && (word_q == "begin");
    is_fork  = !bad_q && (len_q == 3'd4) && (word_q[31:0] == "fork");
    is_join  = !bad_q && (len_q == 3'd4) && (word_q[31:0] == "join");
    is_end   = !bad_q && (len_q == 3'd3) && (word_q[23:0] == "end");
  end

  always_comb begin
    word_d     = word_q;
    len_d      = len_q;
    bad_d      = bad_q;
    stack_d    = stack_q;
    depth_d    = depth_q;
    error_d    = error_q;
    overflow_d = overflow_q;
    if (bus.in_valid && (bus.in != 8'h00)) begin
      if (bus.in == 8'h20) begin
        word_d = '0;
        len_d  = '0;
        bad_d  = 1'b0;
        if (is_begin || is_fork) begin
          if (depth_q < DepthMax) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (depth_q == CNT_W'(i)) stack_d[i] = is_fork;
            end
            depth_d = depth_q + CntOne;
          end else begin
            overflow_d = 1'b1;
            error_d    = 1'b1;
          end
        end else if (is_end || is_join) begin
          if (depth_q == '0) begin
            error_d = 1'b1;
          end else begin
            // Mismatched closer still pops so later nesting stays aligned.
            if (top_kind != is_join) error_d = 1'b1;
            depth_d = depth_q - CntOne;
          end
        end
      end else begin
        word_d = {word_q[31:0], ch_lower};
        if (len_q != 3'd6) len_d = len_q + 3'd1;
        if (!is_letter || (len_q >= 3'd5)) bad_d = 1'b1;
      end
    end
  end

  assign bus.result   = (depth_q == '0) && !error_q;
  assign bus.depth    = depth_q;
  assign bus.top_kind = top_kind;
  assign bus.error    = error_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_block_nest_checker.sv
// Bench for block_nest_checker: two instances (DEPTH 16 and DEPTH 2) fed the same stream and
// compared each cycle to a word/stack reference model, plus vector table and corner sequences.
module tb_block_nest_checker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  block_nest_checker_if #(.CNT_W(5)) bus0 ();
  block_nest_checker_if #(.CNT_W(2)) bus1 ();

  block_nest_checker #(.DEPTH(16), .CNT_W(5)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  block_nest_checker #(.DEPTH(2),  .CNT_W(2)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int tests = 0;
  int fails = 0;

  // Reference model: pending word as byte queue, stack as array + count per instance.
  byte unsigned wq[$];
  int           md[2];
  bit           mk[2][64];
  bit           merr[2];
  bit           movf[2];
  int           lim[2];

  typedef struct {
    bit    rst;
    string txt;
    int    dep;
    bit    res;
    bit    top;
    bit    err;
    bit    ovf;
  } vec_t;

  vec_t  tbl[15];
  string words[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit word_is(input string k);
    byte unsigned c;
    if (wq.size() != k.len()) return 1'b0;
    for (int i = 0; i < k.len(); i++) begin
      c = wq[i];
      if (c >= 8'h41 && c <= 8'h5a) c = c + 8'h20;
      if (c != k[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    wq.delete();
    for (int m = 0; m < 2; m++) begin
      md[m] = 0;
      merr[m] = 1'b0;
      movf[m] = 1'b0;
    end
  endtask

  task automatic model_push(input bit k);
    for (int m = 0; m < 2; m++) begin
      if (md[m] < lim[m]) begin
        mk[m][md[m]] = k;
        md[m]++;
      end else begin
        movf[m] = 1'b1;
        merr[m] = 1'b1;
      end
    end
  endtask

  task automatic model_pop(input bit k);
    for (int m = 0; m < 2; m++) begin
      if (md[m] == 0) merr[m] = 1'b1;
      else begin
        if (mk[m][md[m]-1] != k) merr[m] = 1'b1;
        md[m]--;
      end
    end
  endtask

  task automatic model_byte(input byte unsigned b);
    if (b == 8'h00) return;
    if (b == 8'h20) begin
      if (wq.size() > 0) begin
        if (word_is("begin")) model_push(1'b0);
        else if (word_is("fork")) model_push(1'b1);
        else if (word_is("end")) model_pop(1'b0);
        else if (word_is("join")) model_pop(1'b1);
      end
      wq.delete();
    end else begin
      wq.push_back(b);
    end
  endtask

  task automatic compare_all();
    bit t0, t1;
    t0 = (md[0] > 0) ? mk[0][md[0]-1] : 1'b0;
    t1 = (md[1] > 0) ? mk[1][md[1]-1] : 1'b0;
    chk("d0.depth",    32'(bus0.depth),    md[0]);
    chk("d0.result",   32'(bus0.result),   32'(md[0] == 0 && !merr[0]));
    chk("d0.top_kind", 32'(bus0.top_kind), 32'(t0));
    chk("d0.error",    32'(bus0.error),    32'(merr[0]));
    chk("d0.overflow", 32'(bus0.overflow), 32'(movf[0]));
    chk("d1.depth",    32'(bus1.depth),    md[1]);
    chk("d1.result",   32'(bus1.result),   32'(md[1] == 0 && !merr[1]));
    chk("d1.top_kind", 32'(bus1.top_kind), 32'(t1));
    chk("d1.error",    32'(bus1.error),    32'(merr[1]));
    chk("d1.overflow", 32'(bus1.overflow), 32'(movf[1]));
  endtask

  task automatic tick(input bit v, input byte unsigned b);
    reset         = 1'b1;
    bus0.in_valid = v;
    bus0.in       = b;
    bus1.in_valid = v;
    bus1.in       = b;
    @(posedge clk);
    #1;
    if (v) model_byte(b);
    compare_all();
  endtask

  // Reset asserted together with a valid delimiter: reset must win.
  task automatic do_reset();
    reset         = 1'b0;
    bus0.in_valid = 1'b1;
    bus0.in       = 8'h20;
    bus1.in_valid = 1'b1;
    bus1.in       = 8'h20;
    @(posedge clk);
    #1;
    model_reset();
    compare_all();
    reset = 1'b1;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) tick(1'b1, s[i]);
  endtask

  task automatic chk0(input string n, input int dep, input bit res, input bit top, input bit err,
                      input bit ovf);
    chk({n, ".depth"},    32'(bus0.depth),    dep);
    chk({n, ".result"},   32'(bus0.result),   32'(res));
    chk({n, ".top_kind"}, 32'(bus0.top_kind), 32'(top));
    chk({n, ".error"},    32'(bus0.error),    32'(err));
    chk({n, ".overflow"}, 32'(bus0.overflow), 32'(ovf));
  endtask

  initial begin
    lim[0] = 16;
    lim[1] = 2;
    model_reset();
    reset = 1'b0;
    bus0.in_valid = 1'b0;
    bus0.in = 8'h00;
    bus1.in_valid = 1'b0;
    bus1.in = 8'h00;

    tbl[0]  = '{1'b1, "a ",                   0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, "Begin ",               1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, "enD ",                 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, "begin fork ",          2, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, "join ",                1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, "end ",                 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, "begin join ",          0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, "begin end ",           0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, "end ",                 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, "begin",                0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, " ",                    1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, "be gin endx beginn ",  0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, "BEGIN FORK   fork  ",  3, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, "j0in join x ",         2, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, "join join end ",       0, 1'b0, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) do_reset();
      send(tbl[i].txt);
      chk0($sformatf("vec%0d", i), tbl[i].dep, tbl[i].res, tbl[i].top, tbl[i].err, tbl[i].ovf);
    end

    // Overflow on the small instance, then drain.
    do_reset();
    send("fork fork fork ");
    chk("ovf2.depth",    32'(bus1.depth),    32'd2);
    chk("ovf2.overflow", 32'(bus1.overflow), 32'd1);
    chk("ovf2.error",    32'(bus1.error),    32'd1);
    chk("ovf2.top_kind", 32'(bus1.top_kind), 32'd1);
    send("join join ");
    chk("ovf2.drain_depth",  32'(bus1.depth),  32'd0);
    chk("ovf2.drain_result", 32'(bus1.result), 32'd0);

    // Fill the 16-deep stack exactly, then one more.
    do_reset();
    repeat (16) send("begin ");
    chk0("full16", 16, 1'b0, 1'b0, 1'b0, 1'b0);
    send("fork ");
    chk0("ovf16", 16, 1'b0, 1'b0, 1'b1, 1'b1);
    send("end ");
    chk0("ovf16.pop", 15, 1'b0, 1'b0, 1'b1, 1'b1);

    // Word split by idle cycles, junk words, reset mid-word.
    do_reset();
    send("beg");
    repeat (3) tick(1'b0, 8'h20);
    send("in ");
    chk0("gap", 1, 1'b0, 1'b0, 1'b0, 1'b0);
    send("endd en d ");
    chk0("junk", 1, 1'b0, 1'b0, 1'b0, 1'b0);
    send("en");
    do_reset();
    send("d ");
    chk0("rst_mid", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Null byte inside a word is ignored; delimiter without in_valid is ignored.
    send("be");
    tick(1'b1, 8'h00);
    send("gin fork");
    tick(1'b0, 8'h20);
    chk0("held", 1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 8'h20);
    chk0("null", 2, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized word stream against the model.
    words[0] = "begin";  words[1] = "end";    words[2] = "fork";  words[3] = "join";
    words[4] = "BeGiN";  words[5] = "END";    words[6] = "x";     words[7] = "endx";
    words[8] = "beginn"; words[9] = "j0in";   words[10] = "Fork"; words[11] = "joiN";
    do_reset();
    for (int n = 0; n < 400; n++) begin
      string w;
      if ($urandom_range(59) == 0) do_reset();
      w = words[$urandom_range(11)];
      for (int i = 0; i < w.len(); i++) begin
        if ($urandom_range(7) == 0) tick(1'b0, 8'($urandom));
        if ($urandom_range(15) == 0) tick(1'b1, 8'h00);
        tick(1'b1, w[i]);
      end
      repeat ($urandom_range(1, 2)) tick(1'b1, 8'h20);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
